// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: two-requester round-robin owner of a 1-to-2 decoder path.
// Define ARB_TIMEOUT_EN to build the HOLD_MAX forced-release hold counter.
module rr_grant_ctrl #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       done,
    output logic       sel,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold
        $error("rr_grant_ctrl: HOLD_MAX must be in 2..15");
    end

    state_t state_q;
    state_t state_d;
    logic   sel_q;
    logic   sel_d;
    logic   lsp_q;
    logic   lsp_d;
    logic   own;
    logic   cur;
    logic   rel_now;
    logic   force_now;

    always_comb begin
        own     = (state_q != IDLE);
        cur     = (state_q == OWN1);
        rel_now = own & (done | ~req[cur]);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       tmo_q;
    logic       tmo_d;

    // >= so a counter that saturated while the other side was quiet
    // still hands over as soon as the other side asks.
    always_comb begin
        force_now = own & ~rel_now & req[~cur] & (cnt_q >= HOLD_LAST);
        tmo_d     = force_now;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != IDLE && state_d != state_q) begin
            cnt_d = 4'd0;
        end else if (own && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign force_now = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            lsp_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lsp_q   <= lsp_d;
        end
    end

    // Leaving an owner never returns straight to it: the other side or IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                unique case (req)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = lsp_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                if (rel_now || force_now) begin
                    state_d = req[1] ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (rel_now || force_now) begin
                    state_d = req[0] ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        lsp_d = lsp_q;
        if (state_d == OWN0) begin
            sel_d = 1'b0;
            lsp_d = 1'b0;
        end else if (state_d == OWN1) begin
            sel_d = 1'b1;
            lsp_d = 1'b1;
        end
    end

    always_comb begin
        busy = own;
        sel  = sel_q;
        gnt  = {own & sel_q, own & ~sel_q};
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (HOLD_MAX=4).
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       done;
    logic       sel;
    logic [1:0] gnt;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;

    rr_grant_ctrl #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] g,
                           input logic s, input logic b, input logic t);
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".sel"}, {1'b0, sel}, {1'b0, s});
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, b});
        chk({tag, ".timeout"}, {1'b0, timeout}, {1'b0, t});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (gnt !== 2'b11 && ((gnt === 2'b00) === (busy === 1'b0)))
            else begin
                failures++;
                $error("FAIL invariant: gnt=%0b busy=%0b", gnt, busy);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        req      = 2'b00;
        done     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset_async", 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset_held", 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single requester, then release with done.
        req = 2'b01;
        tick();
        chk_out("s1_grant0", 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("s1_hold0", 2'b01, 1'b0, 1'b1, 1'b0);
        req  = 2'b00;
        done = 1'b1;
        tick();
        chk_out("s1_release", 2'b00, 1'b0, 1'b0, 1'b0);
        done = 1'b0;

        // Fresh reset: tie goes to 0, done alternates without bubble.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 2'b11;
        tick();
        chk_out("s2_tie_first", 2'b01, 1'b0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s2_swap_to1", 2'b10, 1'b1, 1'b1, 1'b0);
        done = 1'b0;
        tick();
        chk_out("s2_keep1", 2'b10, 1'b1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s2_swap_to0", 2'b01, 1'b0, 1'b1, 1'b0);
        done = 1'b0;

        // Owner 0 drops request while 1 asks: direct handoff.
        req = 2'b10;
        tick();
        chk_out("s3_drop_handoff", 2'b10, 1'b1, 1'b1, 1'b0);
        // Owner 1 releases but keeps asking: one IDLE cycle, sel held.
        done = 1'b1;
        tick();
        chk_out("s3_bubble", 2'b00, 1'b1, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_out("s3_regrant1", 2'b10, 1'b1, 1'b1, 1'b0);

        // done while idle is ignored.
        req = 2'b00;
        tick();
        chk_out("s4_idle", 2'b00, 1'b1, 1'b0, 1'b0);
        done = 1'b1;
        tick();
        chk_out("s4_done_idle", 2'b00, 1'b1, 1'b0, 1'b0);
        done = 1'b0;

        // Tie after owner 0 served last goes to 1.
        req = 2'b01;
        tick();
        chk_out("s5_grant0", 2'b01, 1'b0, 1'b1, 1'b0);
        req = 2'b00;
        tick();
        chk_out("s5_idle", 2'b00, 1'b0, 1'b0, 1'b0);
        req = 2'b11;
        tick();
        chk_out("s5_tie_to1", 2'b10, 1'b1, 1'b1, 1'b0);

        // Async reset mid-OWN1, then tie restarts at requester 0.
        #2 rst_n = 1'b0;
        #1;
        chk_out("s6_async_drop", 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("s6_after_reset", 2'b01, 1'b0, 1'b1, 1'b0);

        // Both held, no done: forced alternation only with the counter.
        for (int k = 1; k <= 10; k++) begin
            tick();
`ifdef ARB_TIMEOUT_EN
            if (((k / 4) % 2) == 0) begin
                chk_out($sformatf("s7_hold_k%0d", k), 2'b01, 1'b0, 1'b1,
                        (k % 4) == 0);
            end else begin
                chk_out($sformatf("s7_hold_k%0d", k), 2'b10, 1'b1, 1'b1,
                        (k % 4) == 0);
            end
`else
            chk_out($sformatf("s7_hold_k%0d", k), 2'b01, 1'b0, 1'b1, 1'b0);
`endif
        end

        // Lone owner keeps the path indefinitely, never times out.
        req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_out($sformatf("s8_lone_k%0d", k), 2'b01, 1'b0, 1'b1, 1'b0);
        end

        req = 2'b00;
        tick();
        chk_out("s9_final_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
